// File: rtl/approx_arith_pkg.sv
// Shared widths, state encoding and payload types for the approximate datapath.
package approx_arith_pkg;

    localparam int unsigned OP_W    = 8;
    localparam int unsigned PROD_W  = 16;
    // Partial-product columns below this weight are dropped by the broken array.
    localparam int unsigned BAM_VBL = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_ACC_ENC   = 2'd0;
    localparam logic [STATE_W-1:0] ST_DRAIN_ENC = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE_ENC  = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_ACC   = ST_ACC_ENC,
        ST_DRAIN = ST_DRAIN_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] op1;
        logic [OP_W-1:0] op2;
    } operand_pair_t;

endpackage

// File: rtl/broke_array_multiplier8.sv
// 8x8 broken-array approximate multiplier: an array multiplier whose cells in
// the low-weight columns (i+j < BAM_VBL) are removed. Purely combinational.
module broke_array_multiplier8
    import approx_arith_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] prod_c_o
);

    localparam int unsigned OP_IDX_W   = $clog2(OP_W);
    localparam int unsigned PROD_IDX_W = $clog2(PROD_W);

    logic [PROD_W-1:0] row_c;
    logic [PROD_W-1:0] sum_c;

    // Sum the surviving partial-product rows of the array.
    always_comb begin
        sum_c = '0;
        row_c = '0;
        for (int i = 0; i < int'(OP_W); i++) begin
            row_c = '0;
            for (int j = 0; j < int'(OP_W); j++) begin
                if ((i + j) >= int'(BAM_VBL)) begin
                    row_c[PROD_IDX_W'(i + j)] = a_i[OP_IDX_W'(j)] & b_i[OP_IDX_W'(i)];
                end
            end
            sum_c = sum_c + row_c;
        end
        prod_c_o = sum_c;
    end

endmodule

// File: rtl/approx_mac8_accumulator.sv
// Streams operand pairs through the approximate multiplier and accumulates LEN
// products into a saturating dot-product result presented over valid/ready.
module approx_mac8_accumulator
    import approx_arith_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  operand1_i,
    input  logic [OP_W-1:0]  operand2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] result_o,
    output logic             sat_o
);

    localparam int unsigned      CNT_W    = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    state_e            state_q, state_d;
    operand_pair_t     ops_q, ops_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [PROD_W-1:0] prod_c;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              accept_c;
    logic              retire_c;
    logic [ACC_W:0]    sum_c;

    // A pair presented alongside clear_i is dropped.
    assign accept_c = in_valid_i & in_ready_q & ~clear_i;
    assign retire_c = out_valid_q & out_ready_i;
    assign sum_c    = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);

    broke_array_multiplier8 u_mult (
        .a_i      (ops_q.op1),
        .b_i      (ops_q.op2),
        .prod_c_o (prod_c)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, pipeline advance and saturating accumulate.
    always_comb begin
        state_d    = state_q;
        ops_d      = ops_q;
        s1_valid_d = accept_c;
        s2_valid_d = s1_valid_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        cnt_d      = cnt_q;

        if (accept_c) begin
            ops_d.op1 = operand1_i;
            ops_d.op2 = operand2_i;
            cnt_d     = cnt_q + CNT_W'(1);
        end

        if (s1_valid_q) begin
            prod_d = prod_c;
        end

        if (s2_valid_q) begin
            if (sat_q || sum_c[ACC_W]) begin
                acc_d = ACC_MAX;
                sat_d = 1'b1;
            end else begin
                acc_d = sum_c[ACC_W-1:0];
            end
        end

        case (state_q)
            ST_ACC: begin
                if (accept_c && (cnt_q == CNT_LAST)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // S1 empty means the final product sits in S2 and lands this edge.
                if (!s1_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (retire_c) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase

        if (clear_i) begin
            state_d    = ST_ACC;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            acc_d      = '0;
            cnt_d      = '0;
            sat_d      = 1'b0;
        end

        in_ready_d  = (state_d == ST_ACC);
        out_valid_d = (state_d == ST_DONE);
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ops_q       <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            ops_q       <= ops_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = acc_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_approx_mac8_accumulator.sv
// Bench for approx_mac8_accumulator: a 24-bit/LEN=8 instance (A) and a
// 16-bit/LEN=4 instance (B) driven with random streams against a reference model.
module tb_approx_mac8_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, sat_a;
    logic [7:0]  op1_a, op2_a;
    logic [23:0] result_a;
    logic        clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, sat_b;
    logic [7:0]  op1_b, op2_b;
    logic [15:0] result_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    approx_mac8_accumulator #(.ACC_W(24), .LEN(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .clear_i(clear_a), .in_valid_i(in_valid_a),
        .in_ready_o(in_ready_a), .operand1_i(op1_a), .operand2_i(op2_a),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready_a),
        .result_o(result_a), .sat_o(sat_a)
    );

    approx_mac8_accumulator #(.ACC_W(16), .LEN(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clear_b), .in_valid_i(in_valid_b),
        .in_ready_o(in_ready_b), .operand1_i(op1_b), .operand2_i(op2_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
        .result_o(result_b), .sat_o(sat_b)
    );

    // Approximate product: exact product less every partial-product bit of weight below 2^4.
    function automatic longint unsigned bam_model(int unsigned a, int unsigned b);
        longint unsigned dropped = 0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j <= k; j++)
                dropped += longint'(((a >> j) & 1) & ((b >> (k - j)) & 1)) << k;
        return longint'(a) * longint'(b) - dropped;
    endfunction

    function automatic logic get_ready(bit sel);
        return sel ? in_ready_b : in_ready_a;
    endfunction
    function automatic logic get_valid(bit sel);
        return sel ? out_valid_b : out_valid_a;
    endfunction
    function automatic logic get_sat(bit sel);
        return sel ? sat_b : sat_a;
    endfunction
    function automatic longint unsigned get_result(bit sel);
        return sel ? longint'(result_b) : longint'(result_a);
    endfunction

    task automatic drive_in(bit sel, logic v, logic [7:0] a, logic [7:0] b);
        if (sel) begin in_valid_b = v; op1_b = a; op2_b = b; end
        else     begin in_valid_a = v; op1_a = a; op2_a = b; end
    endtask

    task automatic set_out_ready(bit sel, logic r);
        if (sel) out_ready_b = r; else out_ready_a = r;
    endtask

    // Presents qa/qb in order with random valid gaps; tracks the saturating expected sum.
    task automatic send_pairs(input bit sel, input int valid_pct, output longint unsigned exp_sum,
                              output bit exp_sat, output int cycles, output bit timeout);
        int idx = 0;
        bit v;
        longint unsigned maxv = sel ? 64'hFFFF : 64'hFF_FFFF;
        exp_sum = 0; exp_sat = 0; cycles = 0; timeout = 0;
        while (idx < qa.size()) begin
            @(negedge clk);
            cycles++;
            if (cycles > 2000) begin timeout = 1; break; end
            v = int'($urandom_range(99)) < valid_pct;
            if (v) drive_in(sel, 1'b1, qa[idx], qb[idx]);
            else   drive_in(sel, 1'b0, 8'($urandom), 8'($urandom));
            if (v && get_ready(sel)) begin
                exp_sum += bam_model(qa[idx], qb[idx]);
                if (exp_sum > maxv) begin exp_sum = maxv; exp_sat = 1; end
                idx++;
            end
        end
    endtask

    // Waits for out_valid while throwing random pairs at the (not ready) input.
    task automatic wait_result(input bit sel, output int lat, output bit timeout);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            drive_in(sel, 1'($urandom), 8'($urandom), 8'($urandom));
        end while (!get_valid(sel) && lat < 50);
        timeout = !get_valid(sel);
    endtask

    task automatic do_retire(bit sel);
        set_out_ready(sel, 1'b1);
        drive_in(sel, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        set_out_ready(sel, 1'b0);
    endtask

    task automatic fill(int n, logic [7:0] a, logic [7:0] b, bit rnd);
        qa.delete(); qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(rnd ? 8'($urandom) : a);
            qb.push_back(rnd ? 8'($urandom) : b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready_a got=%b exp=1", in_ready_a); end
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid_a got=%b exp=0", out_valid_a); end
        checks++; if (result_a !== 24'h0) begin errors++; $display("FAIL reset_result_a got=%h exp=0", result_a); end
        checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL reset_sat_a got=%b exp=0", sat_a); end
        checks++; if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || result_b !== 16'h0) begin
            errors++; $display("FAIL reset_b got rdy=%b vld=%b res=%h exp 1/0/0", in_ready_b, out_valid_b, result_b); end
    endtask

    task automatic test_basic();
        longint unsigned es; bit esat, to; int cyc, lat;
        fill(8, 8'h80, 8'h80, 0);
        send_pairs(0, 100, es, esat, cyc, to);
        checks++; if (to || cyc != 8) begin errors++; $display("FAIL basic_accept_cycles got=%0d exp=8", cyc); end
        wait_result(0, lat, to);
        checks++; if (to || lat != 3) begin errors++; $display("FAIL basic_latency got=%0d negedges exp=3", lat); end
        checks++; if (result_a !== 24'h020000) begin errors++; $display("FAIL basic_result got=%h exp=020000", result_a); end
        checks++; if (get_result(0) != es) begin errors++; $display("FAIL basic_model got=%h exp=%h", result_a, es); end
        checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL basic_sat got=%b exp=0", sat_a); end
        do_retire(0);
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || result_a !== 24'h0) begin
            errors++; $display("FAIL basic_retire got vld=%b rdy=%b res=%h exp 0/1/0", out_valid_a, in_ready_a, result_a); end
    endtask

    task automatic test_backpressure();
        longint unsigned es; bit esat, to; int cyc, lat, bad;
        fill(8, 8'h00, 8'hAB, 0);
        send_pairs(0, 100, es, esat, cyc, to);
        wait_result(0, lat, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got=no out_valid exp=out_valid"); end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid_a !== 1'b1 || result_a !== 24'h0 || in_ready_a !== 1'b0 || sat_a !== 1'b0) bad++;
            drive_in(0, 1'b1, 8'($urandom), 8'($urandom));
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", bad); end
        checks++; if (out_valid_a !== 1'b1 || result_a !== 24'h0) begin
            errors++; $display("FAIL bp_still_valid got vld=%b res=%h exp 1/0", out_valid_a, result_a); end
        do_retire(0);
        checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            errors++; $display("FAIL bp_retire got rdy=%b vld=%b exp 1/0", in_ready_a, out_valid_a); end
    endtask

    task automatic test_saturation();
        longint unsigned es; bit esat, to; int cyc, lat;
        fill(4, 8'hFF, 8'hFF, 0);
        send_pairs(1, 100, es, esat, cyc, to);
        wait_result(1, lat, to);
        checks++; if (to || result_b !== 16'hFFFF) begin errors++; $display("FAIL sat_result got=%h exp=ffff", result_b); end
        checks++; if (sat_b !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b exp=1", sat_b); end
        do_retire(1);
        qa.delete(); qb.delete();
        for (int i = 0; i < 4; i++) begin qa.push_back(8'($urandom_range(63))); qb.push_back(8'($urandom_range(63))); end
        send_pairs(1, 70, es, esat, cyc, to);
        wait_result(1, lat, to);
        checks++; if (to || get_result(1) != es) begin errors++; $display("FAIL sat_fresh_result got=%h exp=%h", result_b, es); end
        checks++; if (sat_b !== 1'b0) begin errors++; $display("FAIL sat_fresh_flag got=%b exp=0", sat_b); end
        do_retire(1);
    endtask

    task automatic test_random_mix();
        longint unsigned es; bit esat, to; int cyc, lat, extra;
        fill(8, 8'h00, 8'h00, 1);
        qa[0] = 8'h29; qb[0] = 8'h7A; qa[1] = 8'h55; qb[1] = 8'hAA;
        out_ready_a = 1'b1;
        send_pairs(0, 50, es, esat, cyc, to);
        wait_result(0, lat, to);
        checks++; if (to || get_result(0) != es) begin errors++; $display("FAIL mix_result got=%h exp=%h", result_a, es); end
        checks++; if (sat_a !== esat) begin errors++; $display("FAIL mix_sat got=%b exp=%b", sat_a, esat); end
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive_in(0, 1'b0, 8'h00, 8'h00);
            if (out_valid_a === 1'b1) extra++;
            if (k == 0) begin
                checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL mix_ready_after got=%b exp=1", in_ready_a); end
            end
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL mix_one_episode got=%0d extra valid cycles exp=0", extra); end
        out_ready_a = 1'b0;
    endtask

    task automatic test_clear();
        longint unsigned es; bit esat, to; int cyc, lat;
        fill(5, 8'h00, 8'h00, 1);
        send_pairs(0, 100, es, esat, cyc, to);
        @(negedge clk);
        clear_a = 1'b1;
        drive_in(0, 1'b1, 8'hFF, 8'hFF);
        @(negedge clk);
        clear_a = 1'b0;
        drive_in(0, 1'b0, 8'h00, 8'h00);
        checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || result_a !== 24'h0) begin
            errors++; $display("FAIL clear_flush got rdy=%b vld=%b res=%h exp 1/0/0", in_ready_a, out_valid_a, result_a); end
        repeat (3) @(negedge clk);
        checks++; if (result_a !== 24'h0) begin errors++; $display("FAIL clear_no_stale got=%h exp=0", result_a); end
        fill(8, 8'h40, 8'h20, 0);
        send_pairs(0, 100, es, esat, cyc, to);
        wait_result(0, lat, to);
        checks++; if (to || result_a !== 24'h004000) begin errors++; $display("FAIL clear_result got=%h exp=004000", result_a); end
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        checks++; if (out_valid_a !== 1'b0 || result_a !== 24'h0 || in_ready_a !== 1'b1) begin
            errors++; $display("FAIL clear_in_done got vld=%b res=%h rdy=%b exp 0/0/1", out_valid_a, result_a, in_ready_a); end
    endtask

    task automatic test_reset_drain();
        longint unsigned es; bit esat, to; int cyc, bad;
        fill(8, 8'h00, 8'h00, 1);
        qa[0] = 8'hC3; qb[0] = 8'h9D;
        send_pairs(0, 100, es, esat, cyc, to);
        @(negedge clk);
        drive_in(0, 1'b0, 8'h00, 8'h00);
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || result_a !== 24'h0 || sat_a !== 1'b0) begin
            errors++; $display("FAIL rst_async got rdy=%b vld=%b res=%h sat=%b exp 1/0/0/0", in_ready_a, out_valid_a, result_a, sat_a); end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_pulse got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_back_to_back();
        longint unsigned es; bit esat, to; int cyc, lat;
        for (int r = 0; r < 4; r++) begin
            fill(8, 8'h00, 8'h00, 1);
            out_ready_a = 1'b1;
            send_pairs(0, 60 + 10 * r, es, esat, cyc, to);
            wait_result(0, lat, to);
            checks++; if (to || get_result(0) != es || sat_a !== esat) begin
                errors++; $display("FAIL b2b_a_round%0d got=%h/%b exp=%h/%b", r, result_a, sat_a, es, esat); end
        end
        out_ready_a = 1'b0;
        for (int r = 0; r < 3; r++) begin
            fill(4, 8'h00, 8'h00, 1);
            out_ready_b = 1'b1;
            send_pairs(1, 80, es, esat, cyc, to);
            wait_result(1, lat, to);
            checks++; if (to || get_result(1) != es || sat_b !== esat) begin
                errors++; $display("FAIL b2b_b_round%0d got=%h/%b exp=%h/%b", r, result_b, sat_b, es, esat); end
        end
        out_ready_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_a = 1'b0; in_valid_a = 1'b0; op1_a = 8'h00; op2_a = 8'h00; out_ready_a = 1'b0;
        clear_b = 1'b0; in_valid_b = 1'b0; op1_b = 8'h00; op2_b = 8'h00; out_ready_b = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_random_mix();
        test_clear();
        test_reset_drain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
